// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - shared FSM state type and default debounce constants for sr_cmd_gen
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DB_CYCLES_DEF = 16;
  localparam int DB_W_DEF      = 5;

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - 2-flop synchronizer, stable-level debounce counter and rise detect for one button
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            lvl_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Level flips on the DB_CYCLES-th consecutive differing sample, so cnt never exceeds CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced set/clear buttons to single-cycle S/R commands
// SR_CMD_TOGGLE_EN: simultaneous presses issue S=R=1 (toggle); otherwise clear wins.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = DB_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic set_lvl,
  output logic clr_lvl
);

  logic   set_rise;
  logic   clr_rise;
  state_t state;
  state_t state_nx;
  logic   s_nx;
  logic   r_nx;

  sr_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_db_set (
    .clk  (clk),
    .rst  (rst),
    .din  (set_btn),
    .lvl  (set_lvl),
    .rise (set_rise)
  );

  sr_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_db_clr (
    .clk  (clk),
    .rst  (rst),
    .din  (clr_btn),
    .lvl  (clr_lvl),
    .rise (clr_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      S     <= 1'b0;
      R     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      S     <= s_nx;
      R     <= r_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  // Presses seen outside IDLE are dropped; HOLD waits for both buttons to be released.
  always_comb begin
    state_nx = state;
    s_nx     = 1'b0;
    r_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (set_rise || clr_rise) begin
          state_nx = PULSE;
`ifdef SR_CMD_TOGGLE_EN
          s_nx = set_rise;
          r_nx = clr_rise;
`else
          s_nx = set_rise & ~clr_rise;
          r_nx = clr_rise;
`endif
        end
      end
      PULSE: state_nx = HOLD;
      HOLD: begin
        if (!set_lvl && !clr_lvl) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop block.
- Takes two raw asynchronous push-button lines (set, clear) and synchronizes and debounces them.
- Converts their press events into clean single-cycle S/R command pulses on clk.
- Enforces one command per press and a defined resolution for simultaneous presses.

Parameters:
- DB_CYCLES, 16: consecutive stable samples required before a debounced level changes; legal range 2..(2^DB_W - 1).
- DB_W, 5: debounce counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- set_btn  in  1  raw set button; asynchronous, may bounce.
- clr_btn  in  1  raw clear button; asynchronous, may bounce.
- S  out  1  set command to the SR flip-flop; one-cycle pulse.
- R  out  1  reset command to the SR flip-flop; one-cycle pulse.
- busy  out  1  high while a command is being issued or the generator is waiting for release.
- set_lvl  out  1  debounced set button level.
- clr_lvl  out  1  debounced clear button level.

Behaviour:
- Clock and reset: clk is the clock; rst is asynchronous and active-high. On rst, all of the following clear immediately: S, R, busy, set_lvl, clr_lvl, synchronizer flops, debounce counters. FSM goes to IDLE.
- Synchronizer: each button passes through a 2-flop synchronizer, reset value 0.
- Debounce (per channel):
  - The counter increments each cycle the synced value differs from the stable level.
  - The counter clears to 0 on any cycle they match.
  - When the counter equals DB_CYCLES-1 and the values still differ, the stable level flips at that edge and the counter clears.
  - Result: the level changes after exactly DB_CYCLES consecutive differing samples. The counter never wraps.
- Press event: a 0->1 transition of a stable level, detected the cycle after the flip.
- FSM states IDLE, PULSE, HOLD:
  - IDLE: on any press event go to PULSE and register the command. set only -> S=1. clr only -> R=1. Both in the same cycle -> see Optional Feature.
  - PULSE: S/R high for exactly this one cycle. Next state HOLD unconditionally.
  - HOLD: S=R=0. Stay until set_lvl=0 and clr_lvl=0, then go to IDLE.
- Press events arriving in PULSE or HOLD are discarded, never queued. Consequence: holding set and then pressing clear produces no R; both buttons must be released first.
- busy = 1 in PULSE and HOLD; busy is registered.
- Latency: a clean input edge at set_btn that is held stable raises S on clock edge 2 + DB_CYCLES + 1 after first being sampled.
- S and R are never both high, except under the macro case below.
- Mid-operation reset: S/R drop asynchronously with no pulse completion. A button still held at reset release is seen as a fresh press after full debounce and issues one command.
- Bounce shorter than DB_CYCLES never changes the stable level and never generates a command.

Optional Feature:
- Macro SR_CMD_TOGGLE_EN.
- Defined: simultaneous set and clear press events in IDLE produce S=1 and R=1 for one cycle, which is the toggle command to the SR flip-flop.
- Undefined: simultaneous press events produce R=1, S=0 (clear has priority). S=R=1 is unreachable.
- All other behaviour is identical in both builds.

Decomposition:
- Package sr_cmd_pkg holds:
  - the FSM state enum (IDLE, PULSE, HOLD; 2-bit encoding);
  - default constants DB_CYCLES_DEF=16 and DB_W_DEF=5.
- Sub-module sr_debounce (synchronizer + counter + stable level + rise detect) is instantiated twice, once per button. It has parameters DB_CYCLES and DB_W and ports clk, rst, din, lvl, rise.
- The top level holds the FSM and output registers.

Test Plan (DB_CYCLES=4, DB_W=3):
- Reset: assert rst with both buttons low -> S=R=busy=set_lvl=clr_lvl=0. Assert rst mid-PULSE -> S drops within the same cycle.
- Clean set press: set_btn 0->1 and held -> S=1 on exactly the 7th edge for one cycle, R=0. busy stays 1 until set_lvl=0 after release, i.e. 4 stable low samples plus the synchronizer delay.
- Bounce: set_btn toggles with a 3-cycle period for 30 cycles, then returns to 0 -> set_lvl stays 0 and no S pulse occurs.
- Lockout: hold set, then press clr for 20 cycles while set is still held -> exactly one S pulse and no R. Release both, then press clr -> one R pulse.
- Simultaneous press: both buttons rise in the same cycle. Without SR_CMD_TOGGLE_EN -> R=1, S=0 for one cycle. With SR_CMD_TOGGLE_EN -> S=R=1 for one cycle.
- Held through reset: set_btn high, pulse rst for 2 cycles -> exactly one S pulse 7 edges after rst deasserts.
